// File: rtl/fft_twiddle_sequencer_if.sv
// Butterfly scheduling bus between the FFT twiddle sequencer (master) and the
// butterfly datapath (slave).
interface fft_twiddle_sequencer_if #(
    parameter int LOG2N = 5
);
    logic             start;
    logic             bf_ready;
    logic             bf_valid;
    logic [LOG2N-1:0] addr_a;
    logic [LOG2N-1:0] addr_b;
    logic [5:0]       tw_sel_re;
    logic [5:0]       tw_sel_im;
    logic [2:0]       stage;
    logic             busy;
    logic             done;

    modport master (
        input  start,
        input  bf_ready,
        output bf_valid,
        output addr_a,
        output addr_b,
        output tw_sel_re,
        output tw_sel_im,
        output stage,
        output busy,
        output done
    );

    modport slave (
        output start,
        output bf_ready,
        input  bf_valid,
        input  addr_a,
        input  addr_b,
        input  tw_sel_re,
        input  tw_sel_im,
        input  stage,
        input  busy,
        input  done
    );
endinterface

// File: rtl/fft_twiddle_sequencer.sv
// Stage/butterfly walker for an in-place radix-2 DIT FFT: produces memory
// addresses and 64-entry twiddle ROM selects with a valid/ready handshake.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start
// S_RUN  | presenting butterfly (s, j); advances on bf_valid & bf_ready
// S_GAP  | pipeline drain between stages, gap down-counter running
// S_DONE | one-cycle done pulse, then back to idle
module fft_twiddle_sequencer #(
    parameter int LOG2N     = 5,
    parameter int STAGE_GAP = 4
) (
    input logic                     clk,
    input logic                     rst_n,
    fft_twiddle_sequencer_if.master bus
);
    localparam int              N        = 1 << LOG2N;
    localparam logic [5:0]      J_LAST   = 6'(N / 2 - 1);
    localparam logic [2:0]      S_LAST   = 3'(LOG2N - 1);
    localparam int              GW       = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam logic [GW-1:0]   GAP_INIT = (STAGE_GAP > 0) ? GW'(STAGE_GAP - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [5:0]       r_j;
    logic [5:0]       w_j_nxt;
    logic [2:0]       r_s;
    logic [2:0]       w_s_nxt;
    logic [GW-1:0]    r_gap;
    logic [GW-1:0]    w_gap_nxt;

    logic             r_bf_valid;
    logic [LOG2N-1:0] r_addr_a;
    logic [LOG2N-1:0] r_addr_b;
    logic [5:0]       r_tw_sel_re;
    logic [5:0]       r_tw_sel_im;
    logic [2:0]       r_stage;
    logic             r_busy;
    logic             r_done;

    logic             w_fire;
    logic             w_run_nxt;
    logic             w_busy_nxt;
    logic [5:0]       w_half;
    logic [5:0]       w_pos;
    logic [5:0]       w_grp;
    logic [LOG2N-1:0] w_addr_a;
    logic [LOG2N-1:0] w_addr_b;
    logic [5:0]       w_k;

    assign w_fire = r_bf_valid & bus.bf_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_j_nxt     = r_j;
        w_s_nxt     = r_s;
        w_gap_nxt   = r_gap;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_RUN;
                    w_j_nxt     = '0;
                    w_s_nxt     = '0;
                end
            end
            S_RUN: begin
                if (w_fire) begin
                    if (r_j == J_LAST) begin
                        w_j_nxt = '0;
                        if (r_s == S_LAST) begin
                            w_state_nxt = S_DONE;
                            w_s_nxt     = '0;
                        end else if (STAGE_GAP > 0) begin
                            w_state_nxt = S_GAP;
                            w_s_nxt     = r_s + 3'd1;
                            w_gap_nxt   = GAP_INIT;
                        end else begin
                            w_s_nxt = r_s + 3'd1;
                        end
                    end else begin
                        w_j_nxt = r_j + 6'd1;
                    end
                end
            end
            S_GAP: begin
                if (r_gap == '0) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_gap_nxt = r_gap - 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Butterfly outputs are computed from the next (s, j) so they are registered
    // and appear the cycle after a handshake; a stall recomputes identical values.
    always_comb begin
        w_half     = 6'd1 << w_s_nxt;
        w_pos      = w_j_nxt & (w_half - 6'd1);
        w_grp      = w_j_nxt >> w_s_nxt;
        w_addr_a   = LOG2N'((7'(w_grp) << (w_s_nxt + 3'd1)) | 7'(w_pos));
        w_addr_b   = w_addr_a + LOG2N'(w_half);
        w_k        = w_pos << (3'd5 - w_s_nxt);
        w_run_nxt  = (w_state_nxt == S_RUN);
        w_busy_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_GAP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_j         <= '0;
            r_s         <= '0;
            r_gap       <= '0;
            r_bf_valid  <= 1'b0;
            r_addr_a    <= '0;
            r_addr_b    <= '0;
            r_tw_sel_re <= '0;
            r_tw_sel_im <= '0;
            r_stage     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_j         <= w_j_nxt;
            r_s         <= w_s_nxt;
            r_gap       <= w_gap_nxt;
            r_bf_valid  <= w_run_nxt;
            r_addr_a    <= w_run_nxt ? w_addr_a : '0;
            r_addr_b    <= w_run_nxt ? w_addr_b : '0;
            r_tw_sel_re <= w_run_nxt ? (w_k + 6'd48) : '0;
            r_tw_sel_im <= w_run_nxt ? w_k : '0;
            r_stage     <= w_busy_nxt ? w_s_nxt : '0;
            r_busy      <= w_busy_nxt;
            r_done      <= (w_state_nxt == S_DONE);
        end
    end

    assign bus.bf_valid  = r_bf_valid;
    assign bus.addr_a    = r_addr_a;
    assign bus.addr_b    = r_addr_b;
    assign bus.tw_sel_re = r_tw_sel_re;
    assign bus.tw_sel_im = r_tw_sel_im;
    assign bus.stage     = r_stage;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
endmodule
